// File: rtl/sort_pkg.sv
// Shared definitions for the odd-even sorter and its result reader.
package sort_pkg;

  localparam int ELEM_W    = 8;
  localparam int N_DEFAULT = 16;

  // 2-bit state to match the sorter's state register width.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] STREAM = 2'b01;

  function automatic int unsigned elem_lo(input int unsigned idx);
    return idx * ELEM_W;
  endfunction

endpackage

// File: rtl/sort_result_reader.sv
// Captures the sorter's packed result on sort_done and streams it out byte by byte.
// Optional non-decreasing order check enabled by SORT_READER_ORDER_CHECK_EN.
module sort_result_reader
  import sort_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int IDXW = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                sort_done,
  input  logic [ELEM_W*N-1:0] data_in,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ELEM_W-1:0]   out_data,
  output logic [IDXW-1:0]     out_index,
  output logic                out_last,
  output logic                overrun,
  output logic                order_err,
  output logic [1:0]          state
);

  // Handshake: a transfer happens on every rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low the
  // payload (out_data, out_index, out_last) is held and out_valid stays high.

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  logic [ELEM_W*N-1:0] cap;
  logic [IDXW-1:0]     cnt;
  logic                xfer;
  logic                at_last;

  assign out_valid = (state == STREAM);
  assign busy      = out_valid;
  assign out_index = cnt;
  assign at_last   = (cnt == LAST_IDX);
  assign out_last  = out_valid && at_last;
  assign out_data  = cap[elem_lo(32'(cnt)) +: ELEM_W];
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      cnt     <= '0;
      cap     <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sort_done) begin
            cap   <= data_in;
            cnt   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (xfer && at_last) begin
            // A done pulse on the final transfer edge chains the next vector.
            if (sort_done) begin
              cap <= data_in;
            end else begin
              state <= IDLE;
            end
            cnt <= '0;
          end else begin
            if (xfer) cnt <= cnt + IDXW'(1);
            if (sort_done) overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SORT_READER_ORDER_CHECK_EN
  logic [ELEM_W-1:0] prev;

  // Element 0 only seeds prev so each vector is judged on its own.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prev      <= '0;
      order_err <= 1'b0;
    end else if (xfer) begin
      prev <= out_data;
      if ((cnt != '0) && (out_data < prev)) order_err <= 1'b1;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule
